// File: rtl/ahb_sram_slave_pkg.sv
`default_nettype none
// ============================================================================
// Package   : ahb_pkg
// Purpose   : Shared AHB encodings, slave FSM state type and byte-lane helper
//             for the ahb_sram_slave block.
// Revision  : 1.0  initial release
// ============================================================================
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01,
    RESP_RETRY = 2'b10,
    RESP_SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'b000,
    SIZE_HALF = 3'b001,
    SIZE_WORD = 3'b010
  } hsize_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_WAIT = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // Little-endian byte-lane enables for a transfer of the given size/offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001 << a;
      SIZE_HALF: m = 4'b0011 << a;
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sram_slave_if.sv
`default_nettype none
// ============================================================================
// Interface : ahb_sram_slave_if
// Purpose   : AHB master/slave signal bundle for one slave port.
// Revision  : 1.0  initial release
// ============================================================================
interface ahb_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  Hsel;
  logic [ADDR_WIDTH-1:0] Haddr;
  logic                  HWrite;
  logic [1:0]            Htrans;
  logic [2:0]            Hsize;
  logic [2:0]            Hburst;
  logic                  Hready;
  logic [DATA_WIDTH-1:0] HWdata;
  logic                  Hreadyout;
  logic [1:0]            Hresp;
  logic [DATA_WIDTH-1:0] HRdata;

  modport master (
    output Hsel, Haddr, HWrite, Htrans, Hsize, Hburst, Hready, HWdata,
    input  Hreadyout, Hresp, HRdata
  );

  modport slave (
    input  Hsel, Haddr, HWrite, Htrans, Hsize, Hburst, Hready, HWdata,
    output Hreadyout, Hresp, HRdata
  );
endinterface
`default_nettype wire

// File: rtl/ahb_sram_slave_mem.sv
`default_nettype none
// ============================================================================
// Module    : ahb_slave_mem
// Purpose   : DEPTH x DATA_WIDTH word array with per-byte write enables and a
//             combinational read port. Contents are not reset.
// Revision  : 1.0  initial release
// ============================================================================
module ahb_slave_mem #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic [3:0]            we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Byte-lane write; lanes with we_i clear keep their previous contents.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module    : ahb_sram_slave
// Purpose   : AHB slave fronting an on-chip word-organised SRAM. Decodes the
//             address phase, answers OKAY or a two-cycle ERROR response.
// Options   : AHB_SLAVE_WAIT_EN - insert WAIT_CYCLES wait states before every
//             OKAY data phase; when undefined all OKAY transfers are zero-wait.
// Revision  : 1.0  initial release
// ============================================================================
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 1
) (
  input  logic           Hclk,
  input  logic           Hresetn,
  ahb_sram_slave_if.slave bus
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int OFS_W  = IDX_W + 2;
  localparam int REGION = DEPTH * 4;

  state_t             state_q, state_d;
  logic [OFS_W-1:0]   addr_q;
  logic               write_q;
  logic [2:0]         size_q;
  logic               take;
  logic               accept;
  logic               req_err;
  logic [ADDR_WIDTH-1:0] offset;
  logic [3:0]         mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  state_t             ok_next;

  // Burst type and the BUSY/IDLE distinction carry no meaning for this slave.
  logic unused_bits;
  assign unused_bits = ^{bus.Hburst, bus.Htrans[0]};

  assign accept = bus.Hsel & bus.Hready & bus.Htrans[1];
  assign offset = bus.Haddr - BASE_ADDR;

  // Address-phase error decode: out of region, oversize, or misaligned.
  always_comb begin
    req_err = 1'b0;
    if (offset >= ADDR_WIDTH'(REGION)) req_err = 1'b1;
    if (bus.Hsize > SIZE_WORD) req_err = 1'b1;
    if ((bus.Hsize == SIZE_HALF) && bus.Haddr[0]) req_err = 1'b1;
    if ((bus.Hsize == SIZE_WORD) && (bus.Haddr[1:0] != 2'b00)) req_err = 1'b1;
  end

`ifdef AHB_SLAVE_WAIT_EN
  logic [2:0] wait_cnt_q, wait_cnt_d;

  assign ok_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DATA;

  // Wait counter loads on every accept and counts down while stalling.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (take) wait_cnt_d = 3'(WAIT_CYCLES);
    else if (state_q == ST_WAIT) wait_cnt_d = wait_cnt_q - 3'd1;
  end

  // Wait counter register.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) wait_cnt_q <= 3'd0;
    else          wait_cnt_q <= wait_cnt_d;
  end
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;

  assign ok_next = ST_DATA;
`endif

  // Next-state logic; new transfers are taken only while this slave is ready.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          take    = 1'b1;
          state_d = req_err ? ST_ERR1 : ok_next;
        end
      end
`ifdef AHB_SLAVE_WAIT_EN
      ST_WAIT: begin
        if (wait_cnt_q <= 3'd1) state_d = ST_DATA;
      end
`endif
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured address/control; abandoned transfers are lost on reset.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      if (take) begin
        addr_q  <= offset[OFS_W-1:0];
        write_q <= bus.HWrite;
        size_q  <= bus.Hsize;
      end
    end
  end

  // Response and read data, purely a function of the current state.
  always_comb begin
    bus.Hreadyout = 1'b1;
    bus.Hresp     = RESP_OKAY;
    bus.HRdata    = '0;
    case (state_q)
      ST_WAIT: bus.Hreadyout = 1'b0;
      ST_ERR1: begin
        bus.Hreadyout = 1'b0;
        bus.Hresp     = RESP_ERROR;
      end
      ST_ERR2: bus.Hresp = RESP_ERROR;
      ST_DATA: bus.HRdata = mem_rdata;
      default: ;
    endcase
  end

  // Writes commit at the end of the DATA cycle, so a following read sees them.
  assign mem_we = ((state_q == ST_DATA) && write_q) ? lane_mask(size_q, addr_q[1:0]) : 4'b0000;

  ahb_slave_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk_i   (Hclk),
    .we_i    (mem_we),
    .waddr_i (addr_q[OFS_W-1:2]),
    .wdata_i (bus.HWdata),
    .raddr_i (addr_q[OFS_W-1:2]),
    .rdata_o (mem_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module    : tb_ahb_sram_slave
// Purpose   : Self-checking bench for ahb_sram_slave (either build).
// Revision  : 1.0  initial release
// ============================================================================
module tb_ahb_sram_slave;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0;
`ifdef AHB_SLAVE_WAIT_EN
  localparam int EXP_WAITS = 2;
`else
  localparam int EXP_WAITS = 0;
`endif

  logic Hclk = 1'b0;
  logic Hresetn;
  always #5 Hclk = ~Hclk;

  ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ahb_sram_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE),
    .WAIT_CYCLES(2)
  ) dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] ref_mem [DEPTH];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    else n_pass++;
  endtask

  function automatic bit model_err(input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] off;
    off = addr - BASE;
    if (off >= DEPTH * 4) return 1'b1;
    if (size > 3'd2) return 1'b1;
    if (size == 3'd1 && addr[0] != 1'b0) return 1'b1;
    if (size == 3'd2 && addr[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return int'(off >> 2);
  endfunction

  // Bytes from addr%4 up to addr%4 + 2**size - 1 are replaced.
  task automatic model_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    int idx, lo, n;
    idx = model_idx(addr);
    lo  = int'(addr[1:0]);
    n   = 1 << size;
    for (int b = 0; b < 4; b++)
      if (b >= lo && b < lo + n) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
  endtask

  task automatic idle_bus();
    bus.Hsel = 1'b0; bus.Haddr = '0; bus.HWrite = 1'b0; bus.Htrans = 2'b00;
    bus.Hsize = 3'd0; bus.Hburst = 3'd0; bus.Hready = 1'b1; bus.HWdata = '0;
  endtask

  // One non-pipelined transfer; starts and ends 1 time unit after a rising edge.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic [1:0] resp_first, output logic [1:0] resp_last,
                         output int waits);
    bus.Hsel = 1'b1; bus.Htrans = 2'b10; bus.Haddr = addr; bus.HWrite = wr;
    bus.Hsize = size; bus.Hready = 1'b1; bus.Hburst = 3'($urandom_range(0, 7));
    @(posedge Hclk); #1;
    bus.Hsel = 1'b0; bus.Htrans = 2'b00; bus.HWdata = wdata;
    resp_first = bus.Hresp;
    waits = 0;
    while (!bus.Hreadyout && waits < 20) begin
      @(posedge Hclk); #1;
      waits++;
    end
    resp_last = bus.Hresp;
    rdata     = bus.HRdata;
    @(posedge Hclk); #1;
  endtask

  task automatic run_and_check(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata, input string tag);
    logic [31:0] rd, exp_rd;
    logic [1:0]  rf, rl;
    int          w;
    bit          e;
    e      = model_err(addr, size);
    exp_rd = e ? 32'h0 : ref_mem[model_idx(addr)];
    do_xfer(wr, addr, size, wdata, rd, rf, rl, w);
    check({tag, "_waits"}, w, e ? 1 : EXP_WAITS);
    check({tag, "_resp_first"}, {30'd0, rf}, e ? 32'd1 : 32'd0);
    check({tag, "_resp"}, {30'd0, rl}, e ? 32'd1 : 32'd0);
    if (!wr && !e) check({tag, "_rdata"}, rd, exp_rd);
    if (wr && !e) model_write(addr, size, wdata);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, addr;
    logic [1:0]  rf, rl;
    logic [2:0]  size;
    int          w, cyc, sel;
    bit          rdy;

    tbl[0]  = '{1'b1, 32'h10,  3'd2, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h10,  3'd2, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h10,  3'd2, 32'h11223344, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 32'h11,  3'd0, 32'h0000AA00, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 32'h10,  3'd2, 32'h0,        1'b0, 32'h1122AA44};
    tbl[5]  = '{1'b0, 32'h402, 3'd2, 32'h0,        1'b1, 32'h0};
    tbl[6]  = '{1'b0, 32'h400, 3'd2, 32'h0,        1'b1, 32'h0};
    tbl[7]  = '{1'b0, 32'h10,  3'd2, 32'h0,        1'b0, 32'h1122AA44};
    tbl[8]  = '{1'b1, 32'h12,  3'd1, 32'hBEEF0000, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 32'h10,  3'd2, 32'h0,        1'b0, 32'hBEEFAA44};
    tbl[10] = '{1'b1, 32'h13,  3'd1, 32'hFFFFFFFF, 1'b1, 32'h0};
    tbl[11] = '{1'b1, 32'h10,  3'd3, 32'hFFFFFFFF, 1'b1, 32'h0};
    tbl[12] = '{1'b0, 32'h10,  3'd2, 32'h0,        1'b0, 32'hBEEFAA44};

    // Reset values
    Hresetn = 1'b0;
    idle_bus();
    #2;
    check("rst_hreadyout", {31'd0, bus.Hreadyout}, 32'd1);
    check("rst_hresp", {30'd0, bus.Hresp}, 32'd0);
    check("rst_hrdata", bus.HRdata, 32'h0);
    @(posedge Hclk); @(posedge Hclk); #3;
    Hresetn = 1'b1;
    @(posedge Hclk); #1;

    // Bring every word to a known value
    for (int i = 0; i < DEPTH; i++)
      run_and_check(1'b1, BASE + 32'(i * 4), 3'd2, $urandom, "prefill");

    // Directed table
    for (int i = 0; i < 13; i++) begin
      do_xfer(tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].wdata, rd, rf, rl, w);
      check($sformatf("tbl%0d_waits", i), w, tbl[i].exp_err ? 1 : EXP_WAITS);
      check($sformatf("tbl%0d_resp_first", i), {30'd0, rf}, {31'd0, tbl[i].exp_err});
      check($sformatf("tbl%0d_resp", i), {30'd0, rl}, {31'd0, tbl[i].exp_err});
      if (!tbl[i].wr && !tbl[i].exp_err)
        check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_hrdata_idle", i), bus.HRdata, 32'h0);
      if (tbl[i].wr && !tbl[i].exp_err) model_write(tbl[i].addr, tbl[i].size, tbl[i].wdata);
    end

    // Pipelined write @0x20 then read @0x20 in the overlapping address phase
    bus.Hsel = 1'b1; bus.Htrans = 2'b10; bus.Haddr = 32'h20; bus.HWrite = 1'b1;
    bus.Hsize = 3'd2; bus.Hready = 1'b1;
    @(posedge Hclk); #1;
    bus.HWdata = 32'h5; bus.Htrans = 2'b11; bus.HWrite = 1'b0; bus.Haddr = 32'h20;
    cyc = 0;
    do begin
      rdy = bus.Hreadyout;
      bus.Hready = rdy;
      @(posedge Hclk); #1;
      cyc++;
    end while (!rdy && cyc < 20);
    check("pipe_wr_waits", cyc - 1, EXP_WAITS);
    bus.Hsel = 1'b0; bus.Htrans = 2'b00; bus.Hready = 1'b1;
    w = 0;
    while (!bus.Hreadyout && w < 20) begin
      @(posedge Hclk); #1;
      w++;
    end
    check("pipe_rd_waits", w, EXP_WAITS);
    check("pipe_rd_resp", {30'd0, bus.Hresp}, 32'd0);
    check("pipe_rd_data", bus.HRdata, 32'h5);
    @(posedge Hclk); #1;
    model_write(32'h20, 3'd2, 32'h5);

    // No capture without Hsel/Hready; IDLE/BUSY answer zero-wait OKAY
    bus.Hsel = 1'b0; bus.Htrans = 2'b10; bus.HWrite = 1'b1; bus.Haddr = 32'h40;
    bus.Hsize = 3'd2; bus.Hready = 1'b1; bus.HWdata = 32'hFFFFFFFF;
    @(posedge Hclk); #1;
    check("nosel_ready", {31'd0, bus.Hreadyout}, 32'd1);
    bus.Hsel = 1'b1; bus.Hready = 1'b0;
    @(posedge Hclk); #1;
    bus.Hready = 1'b1; bus.Htrans = 2'b00;
    check("noready_ready", {31'd0, bus.Hreadyout}, 32'd1);
    @(posedge Hclk); #1;
    check("idle_sel_ready", {31'd0, bus.Hreadyout}, 32'd1);
    check("idle_sel_resp", {30'd0, bus.Hresp}, 32'd0);
    bus.Htrans = 2'b01;
    @(posedge Hclk); #1;
    check("busy_sel_ready", {31'd0, bus.Hreadyout}, 32'd1);
    check("busy_sel_resp", {30'd0, bus.Hresp}, 32'd0);
    idle_bus();
    @(posedge Hclk); #1;
    run_and_check(1'b0, 32'h40, 3'd2, 32'h0, "nocapture_rd");

    // Reset in the middle of a write data phase to @0x30
    bus.Hsel = 1'b1; bus.Htrans = 2'b10; bus.Haddr = 32'h30; bus.HWrite = 1'b1;
    bus.Hsize = 3'd2; bus.Hready = 1'b1;
    @(posedge Hclk); #1;
    bus.Hsel = 1'b0; bus.Htrans = 2'b00; bus.HWdata = 32'hCAFEF00D;
    check("midrst_busy", {31'd0, bus.Hreadyout}, (EXP_WAITS > 0) ? 32'd0 : 32'd1);
    #1 Hresetn = 1'b0;
    #1;
    check("midrst_hreadyout", {31'd0, bus.Hreadyout}, 32'd1);
    check("midrst_hresp", {30'd0, bus.Hresp}, 32'd0);
    check("midrst_hrdata", bus.HRdata, 32'h0);
    @(posedge Hclk); #3;
    Hresetn = 1'b1;
    idle_bus();
    @(posedge Hclk); #1;
    run_and_check(1'b0, 32'h30, 3'd2, 32'h0, "midrst_rd");

    // Randomized transfers against the reference model
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3)      size = 3'd0;
      else if (sel < 6) size = 3'd1;
      else if (sel < 9) size = 3'd2;
      else              size = 3'($urandom_range(3, 7));
      if ($urandom_range(0, 7) == 0) addr = 32'h400 + 32'($urandom_range(0, 4095));
      else                           addr = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (size == 3'd1) addr[0] = 1'b0;
        if (size == 3'd2) addr[1:0] = 2'b00;
      end
      run_and_check(1'($urandom_range(0, 1)), addr, size, $urandom, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
